// File: rtl/vec_sweep_checker.sv
// vec_sweep_checker
//
// Self-checking exhaustive stimulus engine for small combinational DUTs.
// On an accepted start it walks stim from 0 to 2^IN_W-1. Each vector is held
// for SETTLE+1 cycles and is then compared, for one cycle, against the golden
// model. The engine reports a saturating mismatch count, the first failing
// vector and completion status. All outputs are registered.
//
// Optional build macro:
//   VEC_SWEEP_STOP_ON_ERR_EN - when defined, the first mismatch ends the sweep.
//                              stim stays on the failing vector.
//
// Parameters:
//   IN_W   (1..16)  stimulus width
//   OUT_W  (1..32)  compared output width
//   SETTLE (0..255) extra hold cycles per vector before the compare
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   start           in   sweep request, sampled only in IDLE or DONE
//   stim            out  vector sent to the DUT and the golden model
//   dut_out         in   DUT response
//   exp_out         in   golden-model response
//   busy            out  sweep in progress
//   done            out  sweep complete (until the next start or rst)
//   err_cnt         out  mismatching vectors, saturates at 16'hFFFF
//   first_err_valid out  at least one mismatch seen in this sweep
//   first_err_vec   out  stim of the first mismatch (0 until valid)
module vec_sweep_checker #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  dut_out,
  input  logic [OUT_W-1:0]  exp_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic              first_err_valid,
  output logic [IN_W-1:0]   first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IN_W-1:0] STIM_ZERO = {IN_W{1'b0}};
  localparam logic [IN_W-1:0] STIM_LAST = {IN_W{1'b1}};
  localparam logic [IN_W-1:0] STIM_ONE  = IN_W'(1);
  localparam logic [7:0]      HOLD_INIT = 8'(SETTLE);

  // Full-width response compare.
  function automatic logic out_mismatch(input logic [OUT_W-1:0] a,
                                        input logic [OUT_W-1:0] b);
    return (a != b);
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic [7:0]        hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              fev_valid_q, fev_valid_d;
  logic [IN_W-1:0]   fev_q, fev_d;
  logic              mismatch_s;
  logic              finish_s;

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_cnt_d   = err_cnt_q;
    fev_valid_d = fev_valid_q;
    fev_d       = fev_q;
    mismatch_s  = out_mismatch(dut_out, exp_out);
    finish_s    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_HOLD;
          stim_d      = STIM_ZERO;
          hold_d      = HOLD_INIT;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_cnt_d   = 16'd0;
          fev_valid_d = 1'b0;
          fev_d       = STIM_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      S_HOLD: begin
        // Counter starts at SETTLE, so the hold window is SETTLE+1 cycles.
        if (hold_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (mismatch_s) begin
          err_cnt_d = sat_inc16(err_cnt_q);
          if (!fev_valid_q) begin
            fev_valid_d = 1'b1;
            fev_d       = stim_q;
          end else begin
            fev_d = fev_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
`ifdef VEC_SWEEP_STOP_ON_ERR_EN
        finish_s = mismatch_s || (stim_q == STIM_LAST);
`else
        finish_s = (stim_q == STIM_LAST);
`endif
        if (finish_s) begin
          // stim is left on the last checked vector.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
          stim_d  = stim_q + STIM_ONE;
          hold_d  = HOLD_INIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stim_q      <= STIM_ZERO;
      hold_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= 16'd0;
      fev_valid_q <= 1'b0;
      fev_q       <= STIM_ZERO;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      fev_valid_q <= fev_valid_d;
      fev_q       <= fev_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_valid_q;
  assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_vec_sweep_checker.sv
// Bench for vec_sweep_checker. Two instances: A (IN_W=2, OUT_W=1, SETTLE=1)
// and B (IN_W=3, OUT_W=4, SETTLE=0). A per-sweep failure pattern selects which
// vectors the fake DUT answers wrongly; a reference model derives the expected
// outputs after every edge from the vector index and the pattern.
module tb_vec_sweep_checker;

`ifdef VEC_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [3:0]  pat_a;
  logic [7:0]  pat_b;

  logic [1:0]  stim_a, fvec_a;
  logic        dut_a, exp_a, busy_a, done_a, fvld_a;
  logic [15:0] err_a;

  logic [2:0]  stim_b, fvec_b;
  logic [3:0]  dut_b, exp_b;
  logic        busy_b, done_b, fvld_b;
  logic [15:0] err_b;

  int n_cmp = 0;
  int n_err = 0;

  // Golden model A: xor of the two inputs; the fake DUT flips it on failing vectors.
  always_comb begin
    exp_a = stim_a[0] ^ stim_a[1];
    dut_a = exp_a ^ pat_a[stim_a];
  end

  // Golden model B; a failing vector flips one bit, starting with the MSB at vector 0.
  always_comb begin
    exp_b = {1'b0, stim_b} ^ 4'h5;
    dut_b = exp_b ^ (pat_b[stim_b] ? (4'b1000 >> stim_b[1:0]) : 4'b0000);
  end

  vec_sweep_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a),
    .dut_out(dut_a), .exp_out(exp_a), .busy(busy_a), .done(done_a),
    .err_cnt(err_a), .first_err_valid(fvld_a), .first_err_vec(fvec_a)
  );

  vec_sweep_checker #(.IN_W(3), .OUT_W(4), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b),
    .dut_out(dut_b), .exp_out(exp_b), .busy(busy_b), .done(done_b),
    .err_cnt(err_b), .first_err_valid(fvld_b), .first_err_vec(fvec_b)
  );

  task automatic chk(input string nm, input int j, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (j=%0d): got %0h, expected %0h", nm, j, act, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " stim_a"}, -1, 32'(stim_a), 32'd0);
    chk({tag, " busy_a"}, -1, 32'(busy_a), 32'd0);
    chk({tag, " done_a"}, -1, 32'(done_a), 32'd0);
    chk({tag, " err_a"},  -1, 32'(err_a),  32'd0);
    chk({tag, " fvld_a"}, -1, 32'(fvld_a), 32'd0);
    chk({tag, " fvec_a"}, -1, 32'(fvec_a), 32'd0);
  endtask

  // One full sweep on instance sel, checked after every edge against the model.
  // extra_j >= 0 re-pulses start after edge extra_j while the sweep is busy.
  task automatic run_sweep(input int sel, input logic [7:0] pat, input int extra_j);
    int n, p, f, t_end, kk;
    logic [31:0] e_stim, e_err, e_vld, e_vec;
    logic [31:0] a_stim, a_busy, a_done, a_err, a_vld, a_vec;
    n = (sel == 0) ? 4 : 8;
    p = (sel == 0) ? 3 : 2;              // SETTLE + 2 cycles per vector
    f = -1;
    for (int v = 0; v < n; v++) if (pat[v] && f < 0) f = v;
    t_end = (STOP && f >= 0) ? (f + 1) * p : n * p;
    if (sel == 0) pat_a = pat[3:0]; else pat_b = pat;
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    for (int j = 0; j <= t_end + 2; j++) begin
      @(negedge clk);                    // after edge j, counting the start edge as 0
      start_a = 1'b0;
      start_b = 1'b0;
      // kk = number of vectors whose compare has completed
      kk = (j < t_end) ? j / p : ((STOP && f >= 0) ? f + 1 : n);
      e_stim = (j < t_end) ? 32'(j / p) : 32'(kk - 1);
      e_err = 0; e_vld = 0; e_vec = 0;
      for (int v = 0; v < kk; v++) begin
        if (pat[v]) begin
          e_err++;
          if (e_vld == 0) begin e_vld = 1; e_vec = 32'(v); end
        end
      end
      if (sel == 0) begin
        a_stim = 32'(stim_a); a_busy = 32'(busy_a); a_done = 32'(done_a);
        a_err = 32'(err_a); a_vld = 32'(fvld_a); a_vec = 32'(fvec_a);
      end else begin
        a_stim = 32'(stim_b); a_busy = 32'(busy_b); a_done = 32'(done_b);
        a_err = 32'(err_b); a_vld = 32'(fvld_b); a_vec = 32'(fvec_b);
      end
      chk($sformatf("sweep%0d stim", sel),  j, a_stim, e_stim);
      chk($sformatf("sweep%0d busy", sel),  j, a_busy, (j < t_end) ? 32'd1 : 32'd0);
      chk($sformatf("sweep%0d done", sel),  j, a_done, (j < t_end) ? 32'd0 : 32'd1);
      chk($sformatf("sweep%0d err",  sel),  j, a_err,  e_err);
      chk($sformatf("sweep%0d fvld", sel),  j, a_vld,  e_vld);
      chk($sformatf("sweep%0d fvec", sel),  j, a_vec,  e_vec);
      if (j == extra_j && j < t_end) begin
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [3:0] pat;
    int         err_all;
    int         err_stop;
    int         vec;
    int         vld;
    int         extra_j;
  } row_t;

  row_t tbl[5];
  bit   found;

  initial begin
    tbl[0] = '{pat: 4'b0000, err_all: 0, err_stop: 0, vec: 0, vld: 0, extra_j: 4};
    tbl[1] = '{pat: 4'b0100, err_all: 1, err_stop: 1, vec: 2, vld: 1, extra_j: -1};
    tbl[2] = '{pat: 4'b1111, err_all: 4, err_stop: 1, vec: 0, vld: 1, extra_j: 1};
    tbl[3] = '{pat: 4'b1010, err_all: 2, err_stop: 1, vec: 1, vld: 1, extra_j: -1};
    tbl[4] = '{pat: 4'b1000, err_all: 1, err_stop: 1, vec: 3, vld: 1, extra_j: 9};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pat_a = 4'b0000; pat_b = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    chk("reset busy_b", -1, 32'(busy_b), 32'd0);
    chk("reset err_b",  -1, 32'(err_b),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sweeps on A, each followed by an end-of-sweep summary check.
    for (int r = 0; r < 5; r++) begin
      run_sweep(0, {4'b0000, tbl[r].pat}, tbl[r].extra_j);
      chk($sformatf("table%0d err", r),  -1, 32'(err_a),
          32'(STOP ? tbl[r].err_stop : tbl[r].err_all));
      chk($sformatf("table%0d fvld", r), -1, 32'(fvld_a), 32'(tbl[r].vld));
      chk($sformatf("table%0d fvec", r), -1, 32'(fvec_a), 32'(tbl[r].vec));
    end

    // B: every vector wrong.
    run_sweep(1, 8'hFF, -1);
    chk("allwrong err_b",  -1, 32'(err_b),  STOP ? 32'd1 : 32'd8);
    chk("allwrong fvec_b", -1, 32'(fvec_b), 32'd0);
    chk("allwrong stim_b", -1, 32'(stim_b), STOP ? 32'd0 : 32'd7);

    // Reset in the middle of a sweep, while stim is 2.
    pat_a = 4'b0001;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (stim_a == 2'd2) found = 1'b1; else @(negedge clk);
    end
    chk("midrst reached stim2", -1, 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_a("midrst");
    run_sweep(0, 8'h04, -1);

    // rst and start together: rst wins, start is dropped.
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    chk_reset_a("rst+start");
    @(negedge clk);
    chk("rst+start stays idle", -1, 32'(busy_a), 32'd0);

    // Randomised sweeps on both instances.
    for (int i = 0; i < 10; i++) begin
      run_sweep(int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 12)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
